data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 40 ++++
 rtl/data_mem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load-store unit and the data memory responder.
// The master drives the access request; the slave returns data and completion status.
interface data_mem_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  StoreType;
  logic [2:0]  LoadType;
  logic [31:0] ReadData;
  logic        Ready;
  logic        AddrError;
  logic        Busy;

  modport master (
    output Address,
    output WriteData,
    output MemRead,
    output MemWrite,
    output StoreType,
    output LoadType,
    input  ReadData,
    input  Ready,
    input  AddrError,
    input  Busy
  );

  modport slave (
    input  Address,
    input  WriteData,
    input  MemRead,
    input  MemWrite,
    input  StoreType,
    input  LoadType,
    output ReadData,
    output Ready,
    output AddrError,
    output Busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Big-endian word RAM with byte/half/word loads and stores; subword stores use
// read-modify-write through a synchronous-read RAM.
module data_mem_responder #(
  parameter int DEPTH = 256
) (
  input logic              clk,
  input logic              reset,
  data_mem_responder_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t                  state;
  logic [DATA_W-1:0]       mem [DEPTH];

  // request captured at the sampling edge
  logic [AW+1:0]           addr_p0;
  logic [DATA_W-1:0]       wdata_p0;
  logic [1:0]              stype_p0;
  logic [2:0]              ltype_p0;
  logic                    store_p0;

  logic [DATA_W-1:0]       ram_p1;
  logic [DATA_W-1:0]       merged_p2;
  logic [DATA_W-1:0]       wr_word_p2;

  logic [DATA_W-1:0]       read_data_q;
  logic                    ready_q;
  logic                    aerr_q;
  logic                    busy_q;

  logic [AW-1:0]           idx_p0;
  logic                    unused_addr_hi;

  assign idx_p0         = addr_p0[AW+1:2];
  assign unused_addr_hi = ^bus.Address[31:AW+2];

  assign bus.ReadData  = read_data_q;
  assign bus.Ready     = ready_q;
  assign bus.AddrError = aerr_q;
  assign bus.Busy      = busy_q;

  function automatic logic [1:0] store_size(input logic [1:0] st);
    case (st)
      2'b01:   return SZ_HALF;
      2'b10:   return SZ_BYTE;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] load_size(input logic [2:0] lt);
    case (lt)
      3'b001, 3'b010: return SZ_HALF;
      3'b011, 3'b100: return SZ_BYTE;
      default:        return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: return (a != 2'b00);
      SZ_HALF: return a[0];
      default: return 1'b0;
    endcase
  endfunction

  // Lane 0 (Address[1:0]=00) is the most significant byte.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] w,
                                                     input logic [2:0]        lt,
                                                     input logic [1:0]        a);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[15:0] : w[31:16];
    case (lt)
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {16'h0000, h};
      3'b011:  return {{24{b[7]}}, b};
      3'b100:  return {24'h000000, b};
      default: return w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] w,
                                                    input logic [DATA_W-1:0] d,
                                                    input logic [1:0]        st,
                                                    input logic [1:0]        a);
    logic [DATA_W-1:0] r;
    r = w;
    case (st)
      2'b01: begin
        if (a[1]) r[15:0]  = d[15:0];
        else      r[31:16] = d[15:0];
      end
      2'b10: begin
        case (a)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Control FSM: every output is registered and follows the state it enters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      aerr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.MemWrite || bus.MemRead) begin
            busy_q <= 1'b1;
            if (bus.MemWrite) begin
              if (misaligned(store_size(bus.StoreType), bus.Address[1:0])) begin
                state   <= DONE;
                ready_q <= 1'b1;
                aerr_q  <= 1'b1;
              end else if (store_size(bus.StoreType) == SZ_WORD) begin
                state <= WRITE;
              end else begin
                state <= READ;
              end
            end else begin
              if (misaligned(load_size(bus.LoadType), bus.Address[1:0])) begin
                state   <= DONE;
                ready_q <= 1'b1;
                aerr_q  <= 1'b1;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: state <= MERGE;
        MERGE: begin
          if (store_p0) begin
            state <= WRITE;
          end else begin
            state       <= DONE;
            ready_q     <= 1'b1;
            read_data_q <= load_extract(ram_p1, ltype_p0, addr_p0[1:0]);
          end
        end
        WRITE: begin
          state   <= DONE;
          ready_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // p0: request capture; the last IDLE cycle before leaving IDLE is the sampling edge
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      addr_p0  <= bus.Address[AW+1:0];
      wdata_p0 <= bus.WriteData;
      stype_p0 <= bus.StoreType;
      ltype_p0 <= bus.LoadType;
      store_p0 <= bus.MemWrite;
    end
  end

  // p1: synchronous RAM read and write port
  always_ff @(posedge clk) begin
    if (state == WRITE && !reset) mem[idx_p0] <= wr_word_p2;
    if (state == READ)            ram_p1      <= mem[idx_p0];
  end

  // p2: lane merge for read-modify-write stores
  always_ff @(posedge clk) begin
    if (state == MERGE) merged_p2 <= store_merge(ram_p1, wdata_p0, stype_p0, addr_p0[1:0]);
  end

  assign wr_word_p2 = (store_size(stype_p0) == SZ_WORD) ? wdata_p0 : merged_p2;

endmodule
